// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Load/store data-memory responder with byte-lane strobes,
//               alignment checking and programmable response latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_WIDTH = 7,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH      = 2 ** ADDR_WIDTH;
    localparam int         AW         = ADDR_WIDTH + 2;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;

    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;

    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic [31:0]       r_mem [DEPTH];

    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [1:0]        w_size;
    logic [31:0]       w_wdata;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]        w_strb;
    logic [31:0]       w_wword;
    logic              w_err;
    logic              w_enter_resp;
    logic              w_unused_addr;

    assign w_unused_addr = ^req_addr[31:AW];

    // With LATENCY=1 the accept edge is also the access edge, so the live
    // request fields feed the access path while still in IDLE.
    assign w_we    = (r_state == IDLE) ? req_we             : r_we;
    assign w_addr  = (r_state == IDLE) ? req_addr[AW-1:0]   : r_addr;
    assign w_size  = (r_state == IDLE) ? req_size           : r_size;
    assign w_wdata = (r_state == IDLE) ? req_wdata          : r_wdata;
    assign w_idx   = w_addr[AW-1:2];

    always_comb begin
        w_strb  = 4'b0000;
        w_wword = w_wdata;
        w_err   = 1'b0;
        case (w_size)
            2'b00: begin
                w_strb  = 4'b1000 >> w_addr[1:0];
                w_wword = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = w_addr[1] ? 4'b0011 : 4'b1100;
                w_wword = {2{w_wdata[15:0]}};
                w_err   = w_addr[0];
            end
            2'b10: begin
                w_strb  = 4'b1111;
                w_err   = (w_addr[1:0] != 2'b00);
            end
            default: begin
                w_err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_cnt_next = c_CNT_INIT;
                    w_next     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Request capture and the word array carry no reset.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr[AW-1:0];
            r_size  <= req_size;
            r_wdata <= req_wdata;
        end
        if (!rst && w_enter_resp && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE) && !rst;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed vector bench for dmem_responder at LATENCY 2, 1, 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (7),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_size   (req_size[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // One full request/response transaction, with optional back-pressure.
    task automatic xact(input int d, input string nm, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        int lat;
        logic [31:0] d0;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = addr; req_size[d] = size; req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), 32'(lat_of(d)));
        chk({nm, ".rdata"}, resp_rdata[d], exp_rdata);
        chk({nm, ".err"}, 32'(resp_err[d]), 32'(exp_err));
        d0 = resp_rdata[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold"}, {resp_valid[d], req_ready[d], resp_err[d], 29'd0} ^ 32'(d0 != resp_rdata[d]),
                {1'b1, 1'b0, exp_err, 29'd0});
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk({nm, ".exit"}, {resp_valid[d], req_ready[d], resp_err[d], 29'd0} | resp_rdata[d] & 32'h1fffffff,
            {1'b0, 1'b1, 1'b0, 29'd0});
    endtask

    vec_t vecs [20];

    initial begin
        int n;
        int bad;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_size[d] = 2'b00; req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
        end
        vecs[0]  = '{1'b1, 32'h10,  2'b10, 32'h11223344, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  2'b10, 32'h0,        32'h11223344, 1'b0};
        vecs[2]  = '{1'b1, 32'h13,  2'b00, 32'h000000AB, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  2'b10, 32'h0,        32'h112233AB, 1'b0};
        vecs[4]  = '{1'b1, 32'h10,  2'b01, 32'h0000BEEF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h10,  2'b10, 32'h0,        32'hBEEF33AB, 1'b0};
        vecs[6]  = '{1'b0, 32'h11,  2'b01, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h12,  2'b10, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h10,  2'b11, 32'h55555555, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h10,  2'b10, 32'h0,        32'hBEEF33AB, 1'b0};
        vecs[10] = '{1'b1, 32'h11,  2'b00, 32'hFFFFFF5A, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h10,  2'b10, 32'h0,        32'hBE5A33AB, 1'b0};
        vecs[12] = '{1'b1, 32'h12,  2'b01, 32'hFFFF1234, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h210, 2'b10, 32'h0,        32'hBE5A1234, 1'b0};
        vecs[14] = '{1'b1, 32'h12,  2'b00, 32'h00000077, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h13,  2'b00, 32'h0,        32'hBE5A7734, 1'b0};
        vecs[16] = '{1'b0, 32'h12,  2'b01, 32'h0,        32'hBE5A7734, 1'b0};
        vecs[17] = '{1'b0, 32'h11,  2'b10, 32'h0,        32'h0,        1'b1};
        vecs[18] = '{1'b1, 32'h20,  2'b10, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 32'h20,  2'b10, 32'h0,        32'hCAFEF00D, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", {resp_valid[0], req_ready[0], resp_err[0], 29'd0} | resp_rdata[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.release_ready", 32'(req_ready[0]), 32'd1);

        for (int i = 0; i < 20; i++) begin
            xact(0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        xact(0, "backpressure", 1'b0, 32'h10, 2'b10, 32'h0, 32'hBE5A7734, 1'b0, 5);

        // Reset lands on the RESP-entry edge of a store: nothing is written.
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h20; req_size[0] = 2'b10;
        req_wdata[0] = 32'hDEADBEEF; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait.ready_low", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[0]) bad++;
        end
        chk("rst_wait.no_resp", 32'(bad), 32'd0);
        xact(0, "rst_wait.reload", 1'b0, 32'h20, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        for (int d = 1; d < 3; d++) begin
            xact(d, $sformatf("lat%0d.store", lat_of(d)), 1'b1, 32'h10, 2'b10, 32'h01020304,
                 32'h0, 1'b0, 0);
            xact(d, $sformatf("lat%0d.alias", lat_of(d)), 1'b0, 32'h210, 2'b10, 32'h0,
                 32'h01020304, 1'b0, 0);
            xact(d, $sformatf("lat%0d.half", lat_of(d)), 1'b1, 32'h12, 2'b01, 32'h0000A5C3,
                 32'h0, 1'b0, 0);
            xact(d, $sformatf("lat%0d.reload", lat_of(d)), 1'b0, 32'h10, 2'b00, 32'h0,
                 32'h0102A5C3, 1'b0, 0);
        end

        n = 0;
        n = n + 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
